line_fill_unit: RTL

//  Refill engine downstream of the instruction cache's memory port. Takes one line-refill request
//  (line-aligned byte address) and issues LINE_BYTES/4 sequential 32-bit reads on a word-wide

---
 rtl/line_fill_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/line_fill_unit.sv
// line_fill_unit
//   Instruction-cache refill engine. It accepts one line-aligned refill request
//   and issues LINE_BYTES/4 sequential 32-bit reads on a word bus that allows
//   one outstanding read. The returned words are collected into a shadow line.
//   The finished line is then published on fill_rdata together with a
//   one-cycle fill_rvalid pulse. Only one refill is in flight at a time.
//
// Ports
//   clk, rstn    rising-edge clock; asynchronous active-low reset
//   fill_req     refill request (level, sampled only in IDLE)
//   fill_addr    line address; the offset bits are ignored
//   fill_busy    refill in progress
//   fill_rvalid  one-cycle pulse; fill_rdata holds the complete line
//   fill_rdata   assembled line, word k at [32k +: 32]
//   bus_req      word read request, held until bus_gnt
//   bus_addr     word byte address, 4-byte aligned
//   bus_gnt      request accepted this cycle
//   bus_rvalid   read data valid (at least one cycle after the grant)
//   bus_rdata    read data
module line_fill_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    fill_req,
    input  logic [ADDR_WIDTH-1:0]   fill_addr,
    output logic                    fill_busy,
    output logic                    fill_rvalid,
    output logic [LINE_BYTES*8-1:0] fill_rdata,
    output logic                    bus_req,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic                    bus_gnt,
    input  logic                    bus_rvalid,
    input  logic [31:0]             bus_rdata
);

    localparam int WORDS = LINE_BYTES / 4;
    localparam int OFF   = $clog2(LINE_BYTES);
    localparam int BW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                    state, state_n;
    logic [BW-1:0]             beat, beat_n, beat_inc;
    logic [ADDR_WIDTH-1:0]     base, base_n, bus_addr_n, req_base;
    logic [WORDS-1:0][31:0]    shadow, shadow_n;
    logic [LINE_BYTES*8-1:0]   fill_rdata_n;
    logic                      fill_busy_n, fill_rvalid_n, bus_req_n;
    logic                      last_beat;

    assign req_base  = {fill_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign beat_inc  = beat + 1'b1;
    assign last_beat = (beat == BW'(WORDS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            beat        <= '0;
            base        <= '0;
            shadow      <= '0;
            fill_rdata  <= '0;
            fill_busy   <= 1'b0;
            fill_rvalid <= 1'b0;
            bus_req     <= 1'b0;
            bus_addr    <= '0;
        end else begin
            state       <= state_n;
            beat        <= beat_n;
            base        <= base_n;
            shadow      <= shadow_n;
            fill_rdata  <= fill_rdata_n;
            fill_busy   <= fill_busy_n;
            fill_rvalid <= fill_rvalid_n;
            bus_req     <= bus_req_n;
            bus_addr    <= bus_addr_n;
        end
    end

    always_comb begin
        state_n       = state;
        beat_n        = beat;
        base_n        = base;
        shadow_n      = shadow;
        fill_rdata_n  = fill_rdata;
        fill_busy_n   = fill_busy;
        fill_rvalid_n = 1'b0;
        bus_req_n     = bus_req;
        bus_addr_n    = bus_addr;

        case (state)
            IDLE: begin
                fill_busy_n = 1'b0;
                if (fill_req) begin
                    base_n      = req_base;
                    beat_n      = '0;
                    fill_busy_n = 1'b1;
                    bus_req_n   = 1'b1;
                    bus_addr_n  = req_base;
                    state_n     = ADDR;
                end
            end
            ADDR: begin
                // bus_req is always high here, so a grant is always a real one.
                if (bus_gnt) begin
                    bus_req_n = 1'b0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bus_rvalid) begin
                    shadow_n[beat] = bus_rdata;
                    if (last_beat) begin
                        // Publish the whole line at once. The visible line
                        // never shows a partially refilled state.
                        fill_rdata_n  = shadow_n;
                        fill_rvalid_n = 1'b1;
                        fill_busy_n   = 1'b0;
                        state_n       = DONE;
                    end else begin
                        // base has zero offset bits and the offset stays
                        // below LINE_BYTES, so only the offset bits change.
                        beat_n     = beat_inc;
                        bus_addr_n = base + (ADDR_WIDTH'(beat_inc) << 2);
                        bus_req_n  = 1'b1;
                        state_n    = ADDR;
                    end
                end
            end
            DONE: begin
                // fill_rvalid drops here. fill_req is not looked at until IDLE.
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
